// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the imem req/ack port from curPC, stalls the PC until its
// instruction is accepted, parks one instruction in a skid buffer under ID back-pressure.
module if_fetch_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [31:0]       curPC,
  input  logic              id_stall,
  input  logic              flush,
  output logic              pc_stall,
  output logic [31:0]       pc_plus4,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        fetching;
  logic        accept;
  logic [31:0] fetch_pc;

  // Once a request is on the bus its address is latched so curPC may move (flush) underneath it.
  always_comb begin
    fetching = (state_q == StFetch) || (state_q == StWait);
    fetch_pc = (state_q == StFetch) ? curPC : req_addr_q;
    accept   = fetching && imem_ack && !flush;
  end

  assign pc_stall    = ~accept;
  assign pc_plus4    = curPC + 32'd4;
  assign imem_req    = (state_q != StHold);
  assign imem_addr   = fetch_pc[ADDR_W-1:0];
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;

    unique case (state_q)
      StFetch, StWait: begin
        if (flush) begin
          if (imem_ack) begin
            state_d = StFetch;
          end else begin
            req_addr_d = fetch_pc;
            state_d    = StDrain;
          end
        end else if (imem_ack) begin
          if (id_stall) begin
            buf_pc_d    = fetch_pc;
            buf_instr_d = imem_rdata;
            state_d     = StHold;
          end else begin
            state_d = StFetch;
          end
        end else begin
          req_addr_d = fetch_pc;
          state_d    = StWait;
        end
      end
      StHold: begin
        if (flush || !id_stall) begin
          state_d = StFetch;
        end
      end
      StDrain: begin
        // The ack closes the killed transfer; a further flush just keeps us draining.
        if (imem_ack) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    if (flush) begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (id_stall) begin
      if_id_pc_d    = if_id_pc_q;
    end else if (accept) begin
      if_id_pc_d    = fetch_pc;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
    end else if (state_q == StHold) begin
      if_id_pc_d    = buf_pc_q;
      if_id_instr_d = buf_instr_q;
      if_id_valid_d = 1'b1;
    end else begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q       <= StFetch;
      req_addr_q    <= 32'd0;
      buf_pc_q      <= 32'd0;
      buf_instr_q   <= NOP_INSTR;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, a reset-in-wait sequence, then random traffic
// checked against a transaction-level model (pending-request record plus skid queue).
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK;
  logic        Reset;
  logic [31:0] curPC;
  logic        id_stall;
  logic        flush;
  logic        pc_stall;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  if_fetch_unit #(
    .ADDR_W   (32),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .curPC      (curPC),
    .id_stall   (id_stall),
    .flush      (flush),
    .pc_stall   (pc_stall),
    .pc_plus4   (pc_plus4),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        st;
    logic        ack;
    logic        e_stall;
    logic        e_req;
    logic        chk_addr;
    logic [31:0] e_addr;
    logic [31:0] e_ifpc;
    logic        e_valid;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int n_cmp = 0;
  int n_err = 0;

  vec_t        tbl [20];
  ent_t        skid [$];
  ent_t        ent;
  logic        has_pend, drop;
  logic [31:0] pend_addr, cur_pc, next_pc;
  logic [31:0] m_pc, m_instr;
  logic        m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [31:0] pc, input logic fl, input logic st, input logic ack,
                       input logic [31:0] data_addr);
    curPC      = pc;
    flush      = fl;
    id_stall   = st;
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(data_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    apply(32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    // {pc, flush, id_stall, ack, pc_stall, imem_req, chk_addr, imem_addr, if_id_pc, if_id_valid}
    tbl[0]  = '{32'h0,   0, 0, 1, 0, 1, 1, 32'h0,   32'h0,   1};
    tbl[1]  = '{32'h4,   0, 0, 1, 0, 1, 1, 32'h4,   32'h4,   1};
    tbl[2]  = '{32'h8,   0, 0, 1, 0, 1, 1, 32'h8,   32'h8,   1};
    tbl[3]  = '{32'h10,  0, 0, 0, 1, 1, 1, 32'h10,  32'h8,   0};
    tbl[4]  = '{32'h10,  0, 0, 0, 1, 1, 1, 32'h10,  32'h8,   0};
    tbl[5]  = '{32'h10,  0, 0, 1, 0, 1, 1, 32'h10,  32'h10,  1};
    tbl[6]  = '{32'h20,  0, 1, 1, 0, 1, 1, 32'h20,  32'h10,  1};
    tbl[7]  = '{32'h24,  0, 1, 0, 1, 0, 0, 32'h0,   32'h10,  1};
    tbl[8]  = '{32'h24,  0, 0, 0, 1, 0, 0, 32'h0,   32'h20,  1};
    tbl[9]  = '{32'h24,  0, 0, 1, 0, 1, 1, 32'h24,  32'h24,  1};
    tbl[10] = '{32'h30,  0, 0, 0, 1, 1, 1, 32'h30,  32'h24,  0};
    tbl[11] = '{32'h30,  1, 0, 0, 1, 1, 1, 32'h30,  32'h24,  0};
    tbl[12] = '{32'h100, 0, 0, 0, 1, 1, 1, 32'h30,  32'h24,  0};
    tbl[13] = '{32'h100, 0, 0, 1, 1, 1, 1, 32'h30,  32'h24,  0};
    tbl[14] = '{32'h100, 0, 0, 1, 0, 1, 1, 32'h100, 32'h100, 1};
    tbl[15] = '{32'h104, 1, 0, 1, 1, 1, 1, 32'h104, 32'h100, 0};
    tbl[16] = '{32'h200, 0, 1, 1, 0, 1, 1, 32'h200, 32'h100, 0};
    tbl[17] = '{32'h204, 1, 1, 0, 1, 0, 0, 32'h0,   32'h100, 0};
    tbl[18] = '{32'h300, 0, 0, 1, 0, 1, 1, 32'h300, 32'h300, 1};
    tbl[19] = '{32'hFFFF_FFFC, 0, 0, 1, 0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1};

    do_reset();
    #1;
    chk1("rst_valid", if_id_valid, 1'b0);
    chk32("rst_pc", if_id_pc, 32'd0);
    chk32("rst_instr", if_id_instr, NOP);
    chk1("rst_req", imem_req, 1'b1);
    chk1("rst_pc_stall", pc_stall, 1'b1);
    @(negedge CLK);

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].pc, tbl[i].fl, tbl[i].st, tbl[i].ack, tbl[i].e_addr);
      #1;
      chk1($sformatf("v%0d_pc_stall", i), pc_stall, tbl[i].e_stall);
      chk32($sformatf("v%0d_pc_plus4", i), pc_plus4, tbl[i].pc + 32'd4);
      chk1($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].chk_addr) chk32($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      @(posedge CLK);
      #1;
      chk32($sformatf("v%0d_ifpc", i), if_id_pc, tbl[i].e_ifpc);
      chk1($sformatf("v%0d_valid", i), if_id_valid, tbl[i].e_valid);
      chk32($sformatf("v%0d_instr", i), if_id_instr,
            tbl[i].e_valid ? mem_word(tbl[i].e_ifpc) : NOP);
      @(negedge CLK);
    end

    // Reset while a fetch is waiting: async clear, then fetch restarts at curPC.
    apply(32'h40, 1'b0, 1'b0, 1'b0, 32'h40);
    @(posedge CLK);
    #3;
    Reset = 1'b0;
    #1;
    chk1("rstw_valid", if_id_valid, 1'b0);
    chk32("rstw_ifpc", if_id_pc, 32'd0);
    chk32("rstw_instr", if_id_instr, NOP);
    chk1("rstw_req", imem_req, 1'b1);
    chk32("rstw_addr", imem_addr, 32'h40);
    @(negedge CLK);
    Reset = 1'b1;
    apply(32'h40, 1'b0, 1'b0, 1'b1, 32'h40);
    #1;
    chk1("rstw_accept", pc_stall, 1'b0);
    @(posedge CLK);
    #1;
    chk32("rstw_load_pc", if_id_pc, 32'h40);
    chk1("rstw_load_valid", if_id_valid, 1'b1);
    @(negedge CLK);

    // Random traffic against the transaction-level model.
    do_reset();
    skid.delete();
    has_pend  = 1'b0;
    drop      = 1'b0;
    pend_addr = 32'd0;
    cur_pc    = 32'd0;
    m_pc      = 32'd0;
    m_instr   = NOP;
    m_valid   = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic        fl, st, ack, e_req, acc, loaded;
      logic [31:0] e_addr, ld_pc, ld_instr;
      e_req  = (skid.size() == 0);
      e_addr = has_pend ? pend_addr : cur_pc;
      fl     = ($urandom_range(0, 7) == 0);
      st     = ($urandom_range(0, 2) == 0);
      ack    = e_req && ($urandom_range(0, 1) == 1);
      apply(cur_pc, fl, st, ack, e_addr);
      acc    = e_req && ack && !fl && !(has_pend && drop);
      #1;
      chk1("rnd_pc_stall", pc_stall, !acc);
      chk32("rnd_pc_plus4", pc_plus4, cur_pc + 32'd4);
      chk1("rnd_req", imem_req, e_req);
      if (e_req) chk32("rnd_addr", imem_addr, e_addr);

      loaded   = 1'b0;
      ld_pc    = 32'd0;
      ld_instr = NOP;
      if (e_req && ack) begin
        if (acc) begin
          if (st) begin
            ent.pc    = e_addr;
            ent.instr = mem_word(e_addr);
            skid.push_back(ent);
          end else begin
            loaded   = 1'b1;
            ld_pc    = e_addr;
            ld_instr = mem_word(e_addr);
          end
        end
        has_pend = 1'b0;
        drop     = 1'b0;
      end else if (e_req) begin
        if (!has_pend) begin
          has_pend  = 1'b1;
          pend_addr = cur_pc;
          drop      = fl;
        end else begin
          drop = drop | fl;
        end
      end else if (fl) begin
        skid.delete();
      end else if (!st) begin
        ent      = skid.pop_front();
        loaded   = 1'b1;
        ld_pc    = ent.pc;
        ld_instr = ent.instr;
      end

      if (fl) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end else if (!st) begin
        if (loaded) begin
          m_pc    = ld_pc;
          m_instr = ld_instr;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_instr = NOP;
        end
      end

      if (fl) next_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & ~32'd3);
      else if (acc) next_pc = cur_pc + 32'd4;
      else next_pc = cur_pc;

      @(posedge CLK);
      #1;
      cur_pc = next_pc;
      curPC  = next_pc;
      chk32("rnd_ifpc", if_id_pc, m_pc);
      chk32("rnd_instr", if_id_instr, m_instr);
      chk1("rnd_valid", if_id_valid, m_valid);
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
